inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Encoder side of the immediate datapath: packs decoded fields (opcode, funct, regs, 64-bit imm) into a 32-bit RV64I word.
//  Each I/I64/Load/Store/Branch/Jalr/Jal/Auipc/Lui request gets a range check on its immediate and yields one word.
//  It also expands the LI pseudo-op into ADDI, or LUI+ADDIW, over a valid/ready stream.
//  Sits between the test-program generator / boot-ROM builder and the instruction memory write port.
// PARAMETERS
//  DATA_WIDTH  64  width of req_imm_i; must be >= 32
// PORTS
//  clk_i          in   1           clock, rising edge
//  rst_ni         in   1           asynchronous active-low reset
//  req_valid_i    in   1           request valid
//  req_ready_o    out  1           request accepted when valid&ready on a clk_i edge
//  req_li_i       in   1           1: LI pseudo-op (uses rd, imm only); 0: raw encode
//  req_opcode_i   in   7           opcode (ignored when req_li_i=1)
//  req_funct3_i   in   3           funct3 (I/I64/Load/Store/Branch/Jalr)
//  req_funct7_i   in   7           funct7 (shift-imm forms only; overrides imm[11:5])
//  req_rd_i       in   5           destination register
//  req_rs1_i      in   5           source 1
//  req_rs2_i      in   5           source 2 (Store/Branch)
//  req_imm_i      in   DATA_WIDTH  immediate, full-value byte offset/constant (not pre-shifted)
//  inst_valid_o   out  1           output word valid
//  inst_ready_i   in   1           consumer ready
//  inst_o         out  32          encoded instruction
//  inst_err_o     out  1           1: request rejected; inst_o=32'h0 on that beat
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=IDLE, inst_valid_o=0, inst_o=0, inst_err_o=0, req_ready_o=0 while in reset.
//  Handshakes
//   - req_ready_o = (state==IDLE) && (!inst_valid_o || inst_ready_i).
//   - The output register holds inst_o/inst_err_o stable while inst_valid_o && !inst_ready_i.
//  Latency: 1 cycle from request acceptance to inst_valid_o; back-to-back single-word requests give full throughput.
//  Range rules (imm viewed as signed DATA_WIDTH):
//   - I/I64/Load/Jalr/Store: -2048..2047.
//   - Branch: -4096..4094 and even. Jal: -2^20..2^20-2 and even.
//   - Auipc/Lui: imm[11:0]==0 and imm equals sext of imm[31:0].
//   - Opcode outside these nine: error.
//   - Any violation -> one beat with inst_err_o=1, inst_o=0.
//  Bit packing:
//   - Store: imm[11:5]->[31:25], imm[4:0]->[11:7].
//   - Branch: imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7].
//   - Jal: imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12].
//   - U-type: imm[31:12]->[31:12].
//   - Shift forms (funct3 001/101 on Ity/I64ty): [31:25]=funct7.
//  LI FSM, states IDLE, EMIT_LO:
//   - Range: imm must equal sext(imm[31:0]), else error beat.
//   - imm fits 12-bit signed: emit ADDI rd,x0,imm; stay IDLE.
//   - Otherwise: hi=(imm[31:0]+32'h800)>>12 (20-bit, wraps mod 2^20); lo=imm[31:0]-(hi<<12) as 12-bit signed.
//   - Emit LUI rd,hi first. If lo!=0, go to EMIT_LO (req_ready_o=0) and emit ADDIW rd,rd,lo once the LUI beat is taken; then IDLE.
//   - If lo==0, emit the LUI only.
//   - ADDIW (not ADDI) is mandatory so 32'h7FFFF800..32'h7FFFFFFF wrap correctly.
//  Reset mid-sequence drops the pending ADDIW; there is no partial-output recovery.
// STRUCTURE
//  - Shared package riscv_pkg: opcode localparams (OPC_ITY 7'h13, OPC_I64 7'h1b, OPC_LOAD 7'h03, OPC_STORE 7'h23,
//    OPC_BRANCH 7'h63, OPC_JALR 7'h67, OPC_JAL 7'h6f, OPC_AUIPC 7'h17, OPC_LUI 7'h37),
//    plus F3_ADDI=3'b000 and the enc_state_e typedef {IDLE, EMIT_LO}.
//  - One sub-module: imm_range_check (combinational, opcode+imm -> ok).
//  - The FSM and output register stay in inst_encoder.
// TESTING
//  1. Jal rd=1 imm=-4 -> inst_o=32'hFFDFF0EF, err=0. Jal imm=3 -> err=1, inst_o=0.
//  2. Branch beq rs1=1 rs2=2 imm=-4096 -> 32'h80208063. Store sd f3=3 rs1=2 rs2=5 imm=-8 -> 32'hFE513C23.
//  3. LI rd=5 imm=0x12345678 -> LUI 32'h123452B7 then ADDIW 32'h6782829B.
//     LI imm=0x7FFFFFFF -> LUI 32'h800002B7, ADDIW 32'hFFF2829B.
//  4. LI rd=5 imm=-1 -> single ADDI 32'hFFF00293. LI imm=0x1000 -> LUI 32'h000012B7 only.
//     LI imm=64'h1_0000_0000 -> err.
//  5. Backpressure: hold inst_ready_i=0 for 5 cycles mid-LI -> inst_o stable, req_ready_o=0, no beat lost or duplicated.
//  6. Assert rst_ni in EMIT_LO -> inst_valid_o=0 immediately. The first request after reset encodes correctly.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64I encoding constants and the LI expansion state type.
package riscv_pkg;

    localparam logic [6:0] OPC_ITY    = 7'h13;
    localparam logic [6:0] OPC_I64    = 7'h1b;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LUI    = 7'h37;

    localparam logic [2:0] F3_ADDI = 3'b000;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        EMIT_LO = 1'b1
    } enc_state_e;

endpackage

// File: rtl/imm_range_check.sv
// Combinational immediate legality check for the nine encodable opcodes.
module imm_range_check
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [6:0]            opcode_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic                  ok_o
);

    logic fits12, fits13, fits21, fits32, even;

    // A value fits an N-bit signed field when every bit above N-1 copies bit N-1.
    assign fits12 = (imm_i[DATA_WIDTH-1:11] == {(DATA_WIDTH-11){imm_i[11]}});
    assign fits13 = (imm_i[DATA_WIDTH-1:12] == {(DATA_WIDTH-12){imm_i[12]}});
    assign fits21 = (imm_i[DATA_WIDTH-1:20] == {(DATA_WIDTH-20){imm_i[20]}});
    assign fits32 = (imm_i[DATA_WIDTH-1:31] == {(DATA_WIDTH-31){imm_i[31]}});
    assign even   = ~imm_i[0];

    always_comb begin
        ok_o = 1'b0;
        case (opcode_i)
            OPC_ITY, OPC_I64, OPC_LOAD, OPC_JALR, OPC_STORE: ok_o = fits12;
            OPC_BRANCH:           ok_o = fits13 && even;
            OPC_JAL:              ok_o = fits21 && even;
            OPC_AUIPC, OPC_LUI:   ok_o = fits32 && (imm_i[11:0] == 12'h000);
            default:              ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded fields into RV64I words and expands LI into ADDI or LUI(+ADDIW).
module inst_encoder
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_li_i,
    input  logic [6:0]            req_opcode_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [6:0]            req_funct7_i,
    input  logic [4:0]            req_rd_i,
    input  logic [4:0]            req_rs1_i,
    input  logic [4:0]            req_rs2_i,
    input  logic [DATA_WIDTH-1:0] req_imm_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [31:0]           inst_o,
    output logic                  inst_err_o,
    output enc_state_e            dbg_state_o
);

    enc_state_e  state_q, state_d;
    logic        inst_valid_q, inst_err_q, err_d, load_out;
    logic [31:0] inst_q, word_d, raw_word, li_word, addiw_word;
    logic [11:0] lo_q;
    logic [4:0]  rd_q;
    logic [19:0] li_hi;
    logic        range_ok, li_fit32, li_fit12, li_need_lo, out_free, req_take;

    imm_range_check #(.DATA_WIDTH(DATA_WIDTH)) u_range (
        .opcode_i (req_opcode_i),
        .imm_i    (req_imm_i),
        .ok_o     (range_ok)
    );

    // Both streams are valid/ready: a beat moves on a rising edge where valid
    // and ready are both high; the producer holds its payload until then.
    assign out_free    = !inst_valid_q || inst_ready_i;
    assign req_ready_o = rst_ni && (state_q == IDLE) && out_free;
    assign req_take    = req_valid_i && req_ready_o;

    assign li_fit32   = (req_imm_i[DATA_WIDTH-1:31] == {(DATA_WIDTH-31){req_imm_i[31]}});
    assign li_fit12   = (req_imm_i[DATA_WIDTH-1:11] == {(DATA_WIDTH-11){req_imm_i[11]}});
    // Rounding the upper part up when bit 11 is set keeps lo in signed 12-bit range.
    assign li_hi      = req_imm_i[31:12] + {19'h0, req_imm_i[11]};
    assign li_need_lo = li_fit32 && !li_fit12 && (req_imm_i[11:0] != 12'h000);

    assign li_word    = li_fit12 ? {req_imm_i[11:0], 5'd0, F3_ADDI, req_rd_i, OPC_ITY}
                                 : {li_hi, req_rd_i, OPC_LUI};
    assign addiw_word = {lo_q, rd_q, F3_ADDI, rd_q, OPC_I64};

    always_comb begin
        raw_word = 32'h0;
        case (req_opcode_i)
            OPC_ITY, OPC_I64, OPC_LOAD, OPC_JALR: begin
                raw_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
                if ((req_opcode_i == OPC_ITY || req_opcode_i == OPC_I64) &&
                    (req_funct3_i == 3'b001 || req_funct3_i == 3'b101))
                    raw_word[31:25] = req_funct7_i;
            end
            OPC_STORE:
                raw_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                            req_imm_i[4:0], req_opcode_i};
            OPC_BRANCH:
                raw_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                            req_imm_i[4:1], req_imm_i[11], req_opcode_i};
            OPC_JAL:
                raw_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                            req_rd_i, req_opcode_i};
            OPC_AUIPC, OPC_LUI:
                raw_word = {req_imm_i[31:12], req_rd_i, req_opcode_i};
            default:
                raw_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_take && req_li_i && li_need_lo) state_d = EMIT_LO;
            EMIT_LO: if (out_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_out = 1'b0;
        word_d   = 32'h0;
        err_d    = 1'b0;
        if (state_q == EMIT_LO) begin
            load_out = out_free;
            word_d   = addiw_word;
        end else if (req_take) begin
            load_out = 1'b1;
            err_d    = req_li_i ? !li_fit32 : !range_ok;
            word_d   = err_d ? 32'h0 : (req_li_i ? li_word : raw_word);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo_q <= 12'h0;
            rd_q <= 5'd0;
        end else if (req_take) begin
            lo_q <= req_imm_i[11:0];
            rd_q <= req_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_err_q   <= 1'b0;
        end else if (load_out) begin
            inst_valid_q <= 1'b1;
            inst_q       <= word_d;
            inst_err_q   <= err_d;
        end else if (inst_ready_i) begin
            inst_valid_q <= 1'b0;
        end
    end

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_err_o   = inst_err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with an arithmetic reference model and a beat scoreboard.
module tb_inst_encoder;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_li_i = 1'b0;
    logic [6:0]  req_opcode_i = 7'h0;
    logic [2:0]  req_funct3_i = 3'h0;
    logic [6:0]  req_funct7_i = 7'h0;
    logic [4:0]  req_rd_i = 5'd0, req_rs1_i = 5'd0, req_rs2_i = 5'd0;
    logic [63:0] req_imm_i = 64'h0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b1;
    logic [31:0] inst_o;
    logic        inst_err_o;
    enc_state_e  dbg_state_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [32:0] exp_q[$];

    inst_encoder #(.DATA_WIDTH(64)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_li_i(req_li_i),
        .req_opcode_i(req_opcode_i), .req_funct3_i(req_funct3_i), .req_funct7_i(req_funct7_i),
        .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_imm_i(req_imm_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
        .inst_err_o(inst_err_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns up to two beats {err, word} for one request.
    task automatic model(input logic li, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [63:0] imm,
                         output int n, output logic [32:0] b0, output logic [32:0] b1);
        longint v, w, hi, lo;
        bit ok;
        v = longint'(imm);
        n = 1; b1 = '0; ok = 1'b0; w = 0;
        if (li) begin
            if (v != longint'(int'(v))) begin
                b0 = {1'b1, 32'h0};
            end else if (v >= -2048 && v <= 2047) begin
                w  = ((v & 'hFFF) << 20) | (longint'(rd) << 7) | 'h13;
                b0 = {1'b0, w[31:0]};
            end else begin
                hi = ((v + 2048) >>> 12) & 'hFFFFF;
                lo = (v - (hi << 12)) & 'hFFF;
                w  = (hi << 12) | (longint'(rd) << 7) | 'h37;
                b0 = {1'b0, w[31:0]};
                if (lo != 0) begin
                    w  = (lo << 20) | (longint'(rd) << 15) | (longint'(rd) << 7) | 'h1b;
                    b1 = {1'b0, w[31:0]};
                    n  = 2;
                end
            end
            return;
        end
        case (opc)
            OPC_ITY, OPC_I64, OPC_LOAD, OPC_JALR: begin
                ok = (v >= -2048 && v <= 2047);
                w  = ((v & 'hFFF) << 20) | (longint'(rs1) << 15) | (longint'(f3) << 12)
                   | (longint'(rd) << 7) | longint'(opc);
                if ((opc == OPC_ITY || opc == OPC_I64) && (f3 == 3'd1 || f3 == 3'd5))
                    w = (w & ~(longint'('h7F) << 25)) | (longint'(f7) << 25);
            end
            OPC_STORE: begin
                ok = (v >= -2048 && v <= 2047);
                w  = (((v >> 5) & 'h7F) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15)
                   | (longint'(f3) << 12) | ((v & 'h1F) << 7) | longint'(opc);
            end
            OPC_BRANCH: begin
                ok = (v >= -4096 && v <= 4094 && (v & 1) == 0);
                w  = (((v >> 12) & 1) << 31) | (((v >> 5) & 'h3F) << 25) | (longint'(rs2) << 20)
                   | (longint'(rs1) << 15) | (longint'(f3) << 12) | (((v >> 1) & 'hF) << 8)
                   | (((v >> 11) & 1) << 7) | longint'(opc);
            end
            OPC_JAL: begin
                ok = (v >= -(longint'(1) << 20) && v <= (longint'(1) << 20) - 2 && (v & 1) == 0);
                w  = (((v >> 20) & 1) << 31) | (((v >> 1) & 'h3FF) << 21) | (((v >> 11) & 1) << 20)
                   | (((v >> 12) & 'hFF) << 12) | (longint'(rd) << 7) | longint'(opc);
            end
            OPC_AUIPC, OPC_LUI: begin
                ok = ((v & 'hFFF) == 0) && (v == longint'(int'(v)));
                w  = (v & 'hFFFFF000) | (longint'(rd) << 7) | longint'(opc);
            end
            default: ok = 1'b0;
        endcase
        b0 = ok ? {1'b0, w[31:0]} : {1'b1, 32'h0};
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic li, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [63:0] imm);
        int n;
        logic [32:0] b0, b1;
        bit acc;
        req_li_i = li; req_opcode_i = opc; req_funct3_i = f3; req_funct7_i = f7;
        req_rd_i = rd; req_rs1_i = rs1; req_rs2_i = rs2; req_imm_i = imm;
        req_valid_i = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready_o) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            tests++; fails++;
            $display("FAIL req_accept: got no ready expected ready within 200 cycles");
            req_valid_i = 1'b0;
            return;
        end
        model(li, opc, f3, f7, rd, rs1, rs2, imm, n, b0, b1);
        exp_q.push_back(b0);
        if (n == 2) exp_q.push_back(b1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic raw(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [63:0] imm);
        send(1'b0, opc, f3, f7, rd, rs1, rs2, imm);
    endtask

    task automatic li(input logic [4:0] rd, input logic [63:0] imm);
        send(1'b1, 7'h0, 3'h0, 7'h0, rd, 5'd0, 5'd0, imm);
    endtask

    task automatic pin(input string name, input logic li_f, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] imm, input int exp_n,
                       input logic [32:0] e0, input logic [32:0] e1);
        int n;
        logic [32:0] b0, b1;
        model(li_f, opc, f3, 7'h0, rd, rs1, rs2, imm, n, b0, b1);
        check({name, "_n"}, 64'(n), 64'(exp_n));
        check({name, "_w0"}, 64'(b0), 64'(e0));
        if (exp_n == 2) check({name, "_w1"}, 64'(b1), 64'(e1));
    endtask

    // ---------------- scoreboard / compare ----------------
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(inst_valid_o), 64'd1);
                check("hold_word", 64'({inst_err_o, inst_o}), 64'(prev_beat));
            end
            if (inst_valid_o && inst_ready_i) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_beat: got %h expected no beat", {inst_err_o, inst_o});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'({inst_err_o, inst_o}), 64'(e));
                end
            end
            prev_stall = inst_valid_o && !inst_ready_i;
            prev_beat  = {inst_err_o, inst_o};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        // Hand-computed anchors for the model itself.
        pin("pin_jal",   0, OPC_JAL,    3'd0, 5'd1, 5'd0, 5'd0, -64'sd4, 1, {1'b0, 32'hFFDFF0EF}, '0);
        pin("pin_jal3",  0, OPC_JAL,    3'd0, 5'd1, 5'd0, 5'd0, 64'd3,   1, {1'b1, 32'h0}, '0);
        pin("pin_beq",   0, OPC_BRANCH, 3'd0, 5'd0, 5'd1, 5'd2, -64'sd4096, 1, {1'b0, 32'h80208063}, '0);
        pin("pin_sd",    0, OPC_STORE,  3'd3, 5'd0, 5'd2, 5'd5, -64'sd8, 1, {1'b0, 32'hFE513C23}, '0);
        pin("pin_li1",   1, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h12345678, 2, {1'b0, 32'h123452B7}, {1'b0, 32'h6782829B});
        pin("pin_li2",   1, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h7FFFFFFF, 2, {1'b0, 32'h800002B7}, {1'b0, 32'hFFF2829B});
        pin("pin_li3",   1, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, -64'sd1, 1, {1'b0, 32'hFFF00293}, '0);
        pin("pin_li4",   1, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h1000, 1, {1'b0, 32'h000012B7}, '0);
        pin("pin_li5",   1, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 64'h1_0000_0000, 1, {1'b1, 32'h0}, '0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst",  64'(inst_o), 64'd0);
        check("rst_err",   64'(inst_err_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_state", 64'(dbg_state_o), 64'(IDLE));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed raw encodes and range boundaries.
        raw(OPC_JAL,    3'd0, 7'h0,  5'd1, 5'd0, 5'd0, -64'sd4);
        raw(OPC_JAL,    3'd0, 7'h0,  5'd1, 5'd0, 5'd0, 64'd3);
        raw(OPC_BRANCH, 3'd0, 7'h0,  5'd0, 5'd1, 5'd2, -64'sd4096);
        raw(OPC_STORE,  3'd3, 7'h0,  5'd0, 5'd2, 5'd5, -64'sd8);
        raw(OPC_ITY,    3'd5, 7'h20, 5'd3, 5'd4, 5'd0, 64'd5);
        raw(OPC_I64,    3'd1, 7'h00, 5'd6, 5'd7, 5'd0, 64'd31);
        raw(OPC_ITY,    3'd0, 7'h7F, 5'd8, 5'd9, 5'd0, -64'sd2048);
        raw(OPC_LOAD,   3'd3, 7'h0,  5'd10, 5'd11, 5'd0, 64'd2047);
        raw(OPC_ITY,    3'd0, 7'h0,  5'd1, 5'd1, 5'd0, -64'sd2049);
        raw(OPC_JALR,   3'd0, 7'h0,  5'd1, 5'd1, 5'd0, 64'd2048);
        raw(OPC_BRANCH, 3'd1, 7'h0,  5'd0, 5'd3, 5'd4, 64'd4094);
        raw(OPC_BRANCH, 3'd1, 7'h0,  5'd0, 5'd3, 5'd4, 64'd4096);
        raw(OPC_BRANCH, 3'd1, 7'h0,  5'd0, 5'd3, 5'd4, 64'd6);
        raw(OPC_BRANCH, 3'd1, 7'h0,  5'd0, 5'd3, 5'd4, 64'd7);
        raw(OPC_JAL,    3'd0, 7'h0,  5'd2, 5'd0, 5'd0, 64'h000F_FFFE);
        raw(OPC_JAL,    3'd0, 7'h0,  5'd2, 5'd0, 5'd0, 64'h0010_0000);
        raw(OPC_JAL,    3'd0, 7'h0,  5'd2, 5'd0, 5'd0, -64'sd1048576);
        raw(OPC_LUI,    3'd0, 7'h0,  5'd9, 5'd0, 5'd0, 64'h1234_5000);
        raw(OPC_LUI,    3'd0, 7'h0,  5'd9, 5'd0, 5'd0, 64'h8000_0000);
        raw(OPC_AUIPC,  3'd0, 7'h0,  5'd9, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000);
        raw(OPC_AUIPC,  3'd0, 7'h0,  5'd9, 5'd0, 5'd0, 64'h1);
        raw(7'h33,      3'd0, 7'h0,  5'd1, 5'd2, 5'd3, 64'd0);

        // LI expansion.
        li(5'd5, 64'h1234_5678);
        li(5'd5, 64'h7FFF_FFFF);
        li(5'd5, -64'sd1);
        li(5'd5, 64'h1000);
        li(5'd5, 64'h1_0000_0000);
        li(5'd7, 64'hFFFF_FFFF_8000_0000);
        li(5'd7, 64'h7FFF_F800);
        li(5'd7, 64'd2048);

        // Back-to-back single-word requests: one per cycle.
        repeat (3) @(posedge clk); #1;
        c0 = cyc;
        raw(OPC_ITY,   3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 64'd1);
        raw(OPC_ITY,   3'd0, 7'h0, 5'd2, 5'd0, 5'd0, 64'd2);
        raw(OPC_STORE, 3'd2, 7'h0, 5'd0, 5'd1, 5'd2, 64'd16);
        li(5'd3, 64'd100);
        check("throughput_cycles", 64'(cyc - c0), 64'd4);

        // Backpressure in the middle of an LI expansion.
        repeat (2) @(posedge clk); #1;
        inst_ready_i = 1'b0;
        li(5'd5, 64'h1234_5678);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_req_ready", 64'(req_ready_o), 64'd0);
            check("bp_valid", 64'(inst_valid_o), 64'd1);
        end
        check("bp_state", 64'(dbg_state_o), 64'(EMIT_LO));
        @(posedge clk); #1 inst_ready_i = 1'b1;
        raw(OPC_JAL, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 64'd8);

        // Reset while the ADDIW is still pending.
        repeat (3) @(posedge clk); #1;
        inst_ready_i = 1'b0;
        li(5'd5, 64'h1234_5678);
        @(negedge clk);
        check("mid_state", 64'(dbg_state_o), 64'(EMIT_LO));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(inst_valid_o), 64'd0);
        check("mid_rst_ready", 64'(req_ready_o), 64'd0);
        check("mid_rst_inst",  64'(inst_o), 64'd0);
        exp_q.delete();
        inst_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        raw(OPC_JAL, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, -64'sd4);
        li(5'd6, 64'h0000_0000_DEAD_B000);
        li(5'd6, 64'hFFFF_FFFF_DEAD_BEEF);

        // Drain.
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        check("end_valid", 64'(inst_valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
